instr_sequencer: RTL and testbench

//  Multi-cycle control FSM that sequences the 9-bit core: instruction fetch, decode,

---
 rtl/instr_sequencer.sv | 133 +++++++++++++
 tb/tb_instr_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/memory sequencer for the 9-bit core.
// Gates PC, IR, RF write and data-memory strobes from decoder flags.
module instr_sequencer #(
  parameter int CNTW        = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            start,
  input  logic            imem_ready,
  input  logic            RegWrite,
  input  logic            MemOrALU,
  input  logic            RegWriteSrc,
  input  logic            MemWrite,
  input  logic            Branch,
  input  logic            exit,
  input  logic            branch_taken,
  input  logic            dmem_ack,
  output logic            ir_load,
  output logic            pc_inc,
  output logic            pc_branch,
  output logic            reg_we,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic            busy,
  output logic            done,
  output logic            mem_err,
  output logic [CNTW-1:0] instr_count
);

  localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic [TW-1:0]   r_timer;
  logic [CNTW-1:0] r_count;
  logic            w_is_load;
  logic            w_tk;
  logic            w_restart;
  logic            w_last_wait;

  assign w_is_load   = RegWrite & ~MemOrALU & ~RegWriteSrc;
  assign w_tk        = Branch & branch_taken;
  assign w_restart   = start & ((r_state == S_IDLE) | (r_state == S_HALT));
  assign w_last_wait = (r_timer == TW'(MEM_TIMEOUT - 1));

  assign busy        = (r_state == S_FETCH) | (r_state == S_DECODE) |
                       (r_state == S_EXEC)  | (r_state == S_MEM);
  assign done        = (r_state == S_HALT);
  assign mem_err     = (r_state == S_ERR);
  assign instr_count = r_count;

  // Next-state and per-cycle strobes from current state and inputs
  always_comb begin
    w_next    = r_state;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_branch = 1'b0;
    reg_we    = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          ir_load = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (exit)                      w_next = S_HALT;
        else if (MemWrite | w_is_load) w_next = S_MEM;
        else                           w_next = S_EXEC;
      end
      S_EXEC: begin
        reg_we    = RegWrite;
        pc_branch = w_tk;
        pc_inc    = ~w_tk;
        w_next    = S_FETCH;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = MemWrite;
        if (dmem_ack) begin
          reg_we = w_is_load;
          pc_inc = 1'b1;
          w_next = S_FETCH;
        end else if (w_last_wait) begin
          w_next = S_ERR;
        end
      end
      S_ERR:   w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // MEM wait timer, cleared whenever the FSM leaves MEM
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      r_timer <= '0;
    else if (r_state == S_MEM && !dmem_ack && w_next == S_MEM)
      r_timer <= r_timer + 1'b1;
    else
      r_timer <= '0;
  end

  // Fetched-instruction counter, saturating, cleared on (re)start
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      r_count <= '0;
    else if (w_restart)
      r_count <= '0;
    else if (ir_load && r_count != {CNTW{1'b1}})
      r_count <= r_count + 1'b1;
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized self-checking bench for instr_sequencer.
// Expected strobes come from an instruction-level model of each kind.
module tb_instr_sequencer;

  localparam int CNTW = 4;
  localparam int MT   = 15;
  localparam int CMAX = (1 << CNTW) - 1;

  localparam int K_ADD  = 0;
  localparam int K_MOV  = 1;
  localparam int K_LW   = 2;
  localparam int K_SW   = 3;
  localparam int K_BR   = 4;
  localparam int K_NOP  = 5;
  localparam int K_EXIT = 6;

  logic Clk = 0;
  logic Reset_n = 0;
  logic start = 0, imem_ready = 0;
  logic RegWrite = 0, MemOrALU = 0, RegWriteSrc = 0;
  logic MemWrite = 0, Branch = 0, exit = 0;
  logic branch_taken = 0, dmem_ack = 0;
  logic ir_load, pc_inc, pc_branch, reg_we;
  logic dmem_req, dmem_we, busy, done, mem_err;
  logic [CNTW-1:0] instr_count;

  logic [8:0] w_obs;
  int tests = 0;
  int errors = 0;
  int exp_cnt = 0;

  instr_sequencer #(.CNTW(CNTW), .MEM_TIMEOUT(MT)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start),
    .imem_ready(imem_ready), .RegWrite(RegWrite),
    .MemOrALU(MemOrALU), .RegWriteSrc(RegWriteSrc),
    .MemWrite(MemWrite), .Branch(Branch), .exit(exit),
    .branch_taken(branch_taken), .dmem_ack(dmem_ack),
    .ir_load(ir_load), .pc_inc(pc_inc),
    .pc_branch(pc_branch), .reg_we(reg_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .busy(busy), .done(done), .mem_err(mem_err),
    .instr_count(instr_count)
  );

  always #5 Clk = ~Clk;

  assign w_obs = {ir_load, pc_inc, pc_branch, reg_we,
                  dmem_req, dmem_we, busy, done, mem_err};

  function automatic logic [8:0] ev(
    bit il, bit pi, bit pb, bit rw,
    bit rq, bit we, bit bz, bit dn, bit er);
    return {il, pi, pb, rw, rq, we, bz, dn, er};
  endfunction

  task automatic set_flags(input int k);
    RegWrite    = (k == K_ADD) || (k == K_MOV) || (k == K_LW);
    MemOrALU    = (k == K_ADD);
    RegWriteSrc = (k == K_MOV);
    MemWrite    = (k == K_SW);
    Branch      = (k == K_BR);
    exit        = (k == K_EXIT);
  endtask

  task automatic cyc;
    @(posedge Clk);
    #1;
  endtask

  task automatic async_reset(input string tag);
    start = 0;
    Reset_n = 0;
    #1;
    tests++;
    if (w_obs !== 9'b0 || instr_count !== '0) begin
      errors++;
      $display("FAIL %s async reset: got %b cnt %0d want 0",
               tag, w_obs, instr_count);
    end
    #2 Reset_n = 1;
    exp_cnt = 0;
    dmem_ack = 0;
    imem_ready = 0;
    cyc();
  endtask

  task automatic start_run(input string tag);
    start = 1;
    cyc();
    start = 0;
    exp_cnt = 0;
    tests++;
    if (instr_count !== '0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s start: cnt %0d busy %b done %b want 0 1 0",
               tag, instr_count, busy, done);
    end
  endtask

  // Drive one instruction from FETCH onward; aw<0 means no ack
  task automatic run_instr(input int k, input int fw,
                           input int aw, input bit tk,
                           input string tag);
    logic [8:0] e;
    bit ack;
    bit is_mem;
    is_mem = (k == K_LW) || (k == K_SW);
    for (int i = 0; i < fw; i++) begin
      imem_ready = 0;
      set_flags($urandom_range(0, 6));
      dmem_ack = 1'($urandom);
      start = 1'($urandom);
      #1;
      e = ev(0, 0, 0, 0, 0, 0, 1, 0, 0);
      tests++;
      if (w_obs !== e) begin
        errors++;
        $display("FAIL %s fetch-wait: got %b want %b", tag, w_obs, e);
      end
      cyc();
    end
    imem_ready = 1;
    set_flags(k);
    branch_taken = tk;
    dmem_ack = 1'($urandom);
    start = 1'($urandom);
    exp_cnt = (exp_cnt < CMAX) ? exp_cnt + 1 : CMAX;
    #1;
    e = ev(1, 0, 0, 0, 0, 0, 1, 0, 0);
    tests++;
    if (w_obs !== e) begin
      errors++;
      $display("FAIL %s fetch: got %b want %b", tag, w_obs, e);
    end
    cyc();
    imem_ready = 1'($urandom);
    dmem_ack = 1'($urandom);
    start = 1'($urandom);
    #1;
    e = ev(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tests++;
    if (w_obs !== e || instr_count !== CNTW'(exp_cnt)) begin
      errors++;
      $display("FAIL %s decode: got %b cnt %0d want %b cnt %0d",
               tag, w_obs, instr_count, e, exp_cnt);
    end
    cyc();
    imem_ready = 0;
    if (k == K_EXIT) begin
      start = 0;
      dmem_ack = 0;
      #1;
      e = ev(0, 0, 0, 0, 0, 0, 0, 1, 0);
      tests++;
      if (w_obs !== e) begin
        errors++;
        $display("FAIL %s halt: got %b want %b", tag, w_obs, e);
      end
      return;
    end
    if (is_mem) begin
      for (int m = 0; m < MT; m++) begin
        ack = (m == aw);
        dmem_ack = ack;
        start = 1'($urandom);
        #1;
        e = ev(0, ack, 0, ack && (k == K_LW),
               1, (k == K_SW), 1, 0, 0);
        tests++;
        if (w_obs !== e) begin
          errors++;
          $display("FAIL %s mem[%0d]: got %b want %b",
                   tag, m, w_obs, e);
        end
        cyc();
        if (ack) begin
          dmem_ack = 0;
          start = 0;
          return;
        end
      end
      dmem_ack = 0;
      start = 0;
      #1;
      e = ev(0, 0, 0, 0, 0, 0, 0, 0, 1);
      tests++;
      if (w_obs !== e) begin
        errors++;
        $display("FAIL %s timeout: got %b want %b", tag, w_obs, e);
      end
      return;
    end
    start = 1'($urandom);
    dmem_ack = 1'($urandom);
    #1;
    e = ev(0, !((k == K_BR) && tk), (k == K_BR) && tk,
           (k == K_ADD) || (k == K_MOV), 0, 0, 1, 0, 0);
    tests++;
    if (w_obs !== e) begin
      errors++;
      $display("FAIL %s exec: got %b want %b", tag, w_obs, e);
    end
    cyc();
    start = 0;
    dmem_ack = 0;
  endtask

  task automatic test_reset;
    Reset_n = 0;
    start = 1;
    imem_ready = 1;
    dmem_ack = 1;
    #2;
    tests++;
    if (w_obs !== 9'b0 || instr_count !== '0) begin
      errors++;
      $display("FAIL reset: got %b cnt %0d want 0", w_obs, instr_count);
    end
    start = 0;
    imem_ready = 0;
    dmem_ack = 0;
    cyc();
    Reset_n = 1;
    cyc();
    cyc();
    tests++;
    if (w_obs !== 9'b0) begin
      errors++;
      $display("FAIL idle: got %b want 0", w_obs);
    end
  endtask

  task automatic test_add;
    start_run("add");
    run_instr(K_ADD, 0, 0, 0, "add");
    tests++;
    if (instr_count !== CNTW'(1)) begin
      errors++;
      $display("FAIL add count: got %0d want 1", instr_count);
    end
  endtask

  task automatic test_load;
    run_instr(K_LW, 2, 3, 0, "lw");
    run_instr(K_MOV, 1, 0, 1, "mov");
    run_instr(K_SW, 0, 0, 0, "sw");
  endtask

  task automatic test_branch;
    run_instr(K_BR, 0, 0, 1, "bre_tk");
    run_instr(K_BR, 0, 0, 0, "bre_nt");
    run_instr(K_NOP, 0, 0, 1, "nop");
  endtask

  task automatic test_timeout;
    run_instr(K_SW, 0, -1, 0, "sw_to");
    start = 1;
    cyc();
    cyc();
    start = 0;
    tests++;
    if (mem_err !== 1'b1 || busy !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL err hold: err %b busy %b req %b want 1 0 0",
               mem_err, busy, dmem_req);
    end
    async_reset("err");
  endtask

  task automatic test_exit;
    start_run("exit");
    run_instr(K_ADD, 1, 0, 0, "exit_a");
    run_instr(K_LW, 0, 1, 0, "exit_b");
    run_instr(K_EXIT, 0, 0, 0, "exit_c");
    tests++;
    if (instr_count !== CNTW'(3)) begin
      errors++;
      $display("FAIL exit count: got %0d want 3", instr_count);
    end
    cyc();
    start_run("restart");
    run_instr(K_ADD, 0, 0, 0, "restart");
  endtask

  task automatic test_async_reset;
    run_instr(K_LW, 0, 7, 0, "pre_mem");
    start = 0;
    cyc();
    cyc();
    imem_ready = 1;
    set_flags(K_LW);
    #1;
    cyc();
    imem_ready = 0;
    cyc();
    cyc();
    tests++;
    if (dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL mid-mem setup: req %b want 1", dmem_req);
    end
    async_reset("mid_mem");
    start_run("fetch_rst");
    cyc();
    cyc();
    async_reset("mid_fetch");
    cyc();
    tests++;
    if (busy !== 1'b0 || instr_count !== '0) begin
      errors++;
      $display("FAIL post reset: busy %b cnt %0d want 0 0",
               busy, instr_count);
    end
  endtask

  task automatic test_random;
    int k;
    int n;
    for (int p = 0; p < 3; p++) begin
      start_run("rand");
      n = $urandom_range(8, 30);
      for (int i = 0; i < n; i++) begin
        k = $urandom_range(0, 5);
        run_instr(k, $urandom_range(0, 3), $urandom_range(0, 5),
                  1'($urandom), "rand");
      end
      run_instr(K_EXIT, $urandom_range(0, 2), 0, 0, "rand_exit");
      tests++;
      if (instr_count !== CNTW'((n + 1 > CMAX) ? CMAX : n + 1)) begin
        errors++;
        $display("FAIL rand count: got %0d want %0d",
                 instr_count, (n + 1 > CMAX) ? CMAX : n + 1);
      end
      cyc();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_load();
    test_branch();
    test_timeout();
    test_exit();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
